// File: rtl/dmem_arbiter_if.sv
// Signal bundle joining the IFU/LSU requesters and the data-memory port to dmem_arbiter.
// The slave view belongs to the arbiter; the master view belongs to requesters and memory.
interface dmem_arbiter_if;
    logic        ifu_req;
    logic [63:0] ifu_addr;
    logic        ifu_gnt;
    logic        ifu_rvalid;
    logic [63:0] ifu_rdata;

    logic        lsu_req;
    logic        lsu_we;
    logic [63:0] lsu_addr;
    logic [63:0] lsu_wdata;
    logic [7:0]  lsu_len;
    logic        lsu_gnt;
    logic        lsu_rvalid;
    logic [63:0] lsu_rdata;
    logic        lsu_err;

    logic        mem_rd_en;
    logic [63:0] mem_rd_addr;
    logic [63:0] mem_rd_data;
    logic        mem_wr_en;
    logic [63:0] mem_wr_addr;
    logic [63:0] mem_wr_data;
    logic [7:0]  mem_wr_len;

    modport slave (
        input  ifu_req, ifu_addr,
        input  lsu_req, lsu_we, lsu_addr, lsu_wdata, lsu_len,
        input  mem_rd_data,
        output ifu_gnt, ifu_rvalid, ifu_rdata,
        output lsu_gnt, lsu_rvalid, lsu_rdata, lsu_err,
        output mem_rd_en, mem_rd_addr, mem_wr_en, mem_wr_addr, mem_wr_data, mem_wr_len
    );

    modport master (
        output ifu_req, ifu_addr,
        output lsu_req, lsu_we, lsu_addr, lsu_wdata, lsu_len,
        output mem_rd_data,
        input  ifu_gnt, ifu_rvalid, ifu_rdata,
        input  lsu_gnt, lsu_rvalid, lsu_rdata, lsu_err,
        input  mem_rd_en, mem_rd_addr, mem_wr_en, mem_wr_addr, mem_wr_data, mem_wr_len
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Shares one data-memory port between the IFU (reads) and the LSU (reads/writes).
// LSU has priority; the IFU is forced through after STARVE_MAX consecutive LSU wins.
module dmem_arbiter #(
    parameter int RD_LAT     = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          rst,
    dmem_arbiter_if.slave bus,
    output logic          busy
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [3:0]  r_starve;
    logic [2:0]  r_wcnt;
    logic        r_owner_lsu;
    logic        r_we;
    logic        w_starve_hit;
    logic        w_lsu_win;
    logic        w_ifu_win;
    logic        w_len_ok;

    logic        r_mem_rd_en;
    logic [63:0] r_mem_rd_addr;
    logic        r_mem_wr_en;
    logic [63:0] r_mem_wr_addr;
    logic [63:0] r_mem_wr_data;
    logic [7:0]  r_mem_wr_len;
    logic        r_lsu_err;
    logic        r_ifu_rvalid;
    logic        r_lsu_rvalid;
    logic [63:0] r_ifu_rdata;
    logic [63:0] r_lsu_rdata;

    assign w_len_ok = bus.lsu_len inside {8'd1, 8'd2, 8'd4, 8'd8};

    // Grants are combinational from IDLE and suppressed while reset is asserted
    always_comb begin
        w_state_nxt  = r_state;
        w_starve_hit = bus.ifu_req && (r_starve == 4'(STARVE_MAX));
        w_lsu_win    = 1'b0;
        w_ifu_win    = 1'b0;
        case (r_state)
            IDLE: begin
                if (rst) begin
                    w_lsu_win = bus.lsu_req && !w_starve_hit;
                    w_ifu_win = bus.ifu_req && !w_lsu_win;
                end
                if (w_lsu_win || w_ifu_win) w_state_nxt = ISSUE;
            end
            ISSUE: begin
                if (r_we)            w_state_nxt = IDLE;
                else if (RD_LAT > 1) w_state_nxt = WAIT;
                else                 w_state_nxt = RESP;
            end
            WAIT:    if (r_wcnt == 3'd1) w_state_nxt = RESP;
            RESP:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_state_nxt;
    end

    // Memory-side strobes are loaded at the grant edge so they appear in the ISSUE cycle
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_starve      <= '0;
            r_wcnt        <= '0;
            r_owner_lsu   <= 1'b0;
            r_we          <= 1'b0;
            r_mem_rd_en   <= 1'b0;
            r_mem_rd_addr <= '0;
            r_mem_wr_en   <= 1'b0;
            r_mem_wr_addr <= '0;
            r_mem_wr_data <= '0;
            r_mem_wr_len  <= '0;
            r_lsu_err     <= 1'b0;
            r_ifu_rvalid  <= 1'b0;
            r_lsu_rvalid  <= 1'b0;
            r_ifu_rdata   <= '0;
            r_lsu_rdata   <= '0;
        end else begin
            r_mem_wr_en  <= 1'b0;
            r_lsu_err    <= 1'b0;
            r_ifu_rvalid <= 1'b0;
            r_lsu_rvalid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (!bus.ifu_req || w_ifu_win)
                        r_starve <= '0;
                    else if (w_lsu_win && r_starve != 4'(STARVE_MAX))
                        r_starve <= r_starve + 4'd1;
                    if (w_lsu_win) begin
                        r_owner_lsu <= 1'b1;
                        r_we        <= bus.lsu_we;
                        if (!bus.lsu_we) begin
                            r_mem_rd_en   <= 1'b1;
                            r_mem_rd_addr <= bus.lsu_addr;
                        end else if (w_len_ok) begin
                            r_mem_wr_en   <= 1'b1;
                            r_mem_wr_addr <= bus.lsu_addr;
                            r_mem_wr_data <= bus.lsu_wdata;
                            r_mem_wr_len  <= bus.lsu_len;
                        end else begin
                            r_lsu_err <= 1'b1;
                        end
                    end else if (w_ifu_win) begin
                        r_owner_lsu   <= 1'b0;
                        r_we          <= 1'b0;
                        r_mem_rd_en   <= 1'b1;
                        r_mem_rd_addr <= bus.ifu_addr;
                    end
                end
                ISSUE: begin
                    r_wcnt <= 3'(RD_LAT - 1);
                    if (RD_LAT == 1) r_mem_rd_en <= 1'b0;
                end
                WAIT: begin
                    r_wcnt <= r_wcnt - 3'd1;
                    if (r_wcnt == 3'd1) r_mem_rd_en <= 1'b0;
                end
                RESP: begin
                    if (r_owner_lsu) begin
                        r_lsu_rdata  <= bus.mem_rd_data;
                        r_lsu_rvalid <= 1'b1;
                    end else begin
                        r_ifu_rdata  <= bus.mem_rd_data;
                        r_ifu_rvalid <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.ifu_gnt     = w_ifu_win;
    assign bus.lsu_gnt     = w_lsu_win;
    assign bus.ifu_rvalid  = r_ifu_rvalid;
    assign bus.ifu_rdata   = r_ifu_rdata;
    assign bus.lsu_rvalid  = r_lsu_rvalid;
    assign bus.lsu_rdata   = r_lsu_rdata;
    assign bus.lsu_err     = r_lsu_err;
    assign bus.mem_rd_en   = r_mem_rd_en;
    assign bus.mem_rd_addr = r_mem_rd_addr;
    assign bus.mem_wr_en   = r_mem_wr_en;
    assign bus.mem_wr_addr = r_mem_wr_addr;
    assign bus.mem_wr_data = r_mem_wr_data;
    assign bus.mem_wr_len  = r_mem_wr_len;
    assign busy            = (r_state != IDLE);
endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: one RD_LAT=1 instance checked through an event scoreboard,
// plus an RD_LAT=3 instance used for the reset-during-read scenario.
`timescale 1ns/1ps
module tb_dmem_arbiter;
    localparam int EV_IGNT = 0, EV_LGNT = 1, EV_RD = 2, EV_WR = 3;
    localparam int EV_ERR = 4, EV_IRV = 5, EV_LRV = 6;

    typedef struct {
        int          kind;
        int          cyc;
        logic [63:0] a;
        logic [63:0] d;
        logic [7:0]  l;
    } ev_t;

    logic clk = 1'b0;
    logic rst;
    logic rst3;
    logic busy1;
    logic busy3;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    ev_t  exp_q[$];

    int          rv3_cnt = 0;
    int          rv3_cyc = 0;
    logic [63:0] rv3_d;
    logic        rv3_ifu;
    logic [63:0] m3a, m3b;

    logic [7:0]  wlen [6];
    bit          wok  [6];

    dmem_arbiter_if bus();
    dmem_arbiter_if bus3();

    dmem_arbiter #(.RD_LAT(1), .STARVE_MAX(4)) dut1 (
        .clk(clk), .rst(rst), .bus(bus), .busy(busy1));
    dmem_arbiter #(.RD_LAT(3), .STARVE_MAX(4)) dut3 (
        .clk(clk), .rst(rst3), .bus(bus3), .busy(busy3));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [63:0] mem_val(input logic [63:0] a);
        if (a == 64'h8000_0000) return 64'h1122_3344_5566_7788;
        return {~a[31:0], a[31:0]};
    endfunction

    // Memory models: data appears RD_LAT cycles after the read enable is sampled
    always @(posedge clk)
        bus.mem_rd_data <= bus.mem_rd_en ? mem_val(bus.mem_rd_addr) : 64'hBAD0_BAD0_BAD0_BAD0;
    always @(posedge clk) begin
        m3a <= bus3.mem_rd_en ? mem_val(bus3.mem_rd_addr) : 64'hBAD3_BAD3_BAD3_BAD3;
        m3b <= m3a;
        bus3.mem_rd_data <= m3b;
    end

    function automatic string kname(input int k);
        case (k)
            EV_IGNT: return "ifu_gnt";
            EV_LGNT: return "lsu_gnt";
            EV_RD:   return "mem_rd";
            EV_WR:   return "mem_wr";
            EV_ERR:  return "lsu_err";
            EV_IRV:  return "ifu_rvalid";
            default: return "lsu_rvalid";
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    task automatic push(input int k, input int c, input logic [63:0] a,
                        input logic [63:0] d, input logic [7:0] l);
        ev_t e;
        e.kind = k; e.cyc = c; e.a = a; e.d = d; e.l = l;
        exp_q.push_back(e);
    endtask

    task automatic observe(input int k, input logic [63:0] a, input logic [63:0] d,
                           input logic [7:0] l);
        int idx;
        idx = -1;
        for (int i = 0; i < exp_q.size(); i++)
            if (idx < 0 && exp_q[i].kind == k) idx = i;
        n_checks++;
        if (idx < 0) begin
            n_fail++;
            $display("FAIL %s unexpected at cycle %0d: got a=%h d=%h len=%0d, want no event",
                     kname(k), cyc, a, d, l);
        end else begin
            if (exp_q[idx].cyc != cyc || exp_q[idx].a !== a || exp_q[idx].d !== d ||
                exp_q[idx].l !== l) begin
                n_fail++;
                $display("FAIL %s: got cyc=%0d a=%h d=%h len=%0d, want cyc=%0d a=%h d=%h len=%0d",
                         kname(k), cyc, a, d, l, exp_q[idx].cyc, exp_q[idx].a, exp_q[idx].d,
                         exp_q[idx].l);
            end
            exp_q.delete(idx);
        end
    endtask

    // Monitor for the RD_LAT=1 instance
    always @(negedge clk) begin
        if (!rst) begin
            chk("reset_outputs_zero", {63'd0, |{bus.ifu_gnt, bus.ifu_rvalid, bus.ifu_rdata,
                bus.lsu_gnt, bus.lsu_rvalid, bus.lsu_rdata, bus.lsu_err, bus.mem_rd_en,
                bus.mem_rd_addr, bus.mem_wr_en, bus.mem_wr_addr, bus.mem_wr_data,
                bus.mem_wr_len, busy1}}, 64'd0);
        end else begin
            if (bus.ifu_gnt)    observe(EV_IGNT, 64'd0, 64'd0, 8'd0);
            if (bus.lsu_gnt)    observe(EV_LGNT, 64'd0, 64'd0, 8'd0);
            if (bus.mem_rd_en)  observe(EV_RD, bus.mem_rd_addr, 64'd0, 8'd0);
            if (bus.mem_wr_en)  observe(EV_WR, bus.mem_wr_addr, bus.mem_wr_data, bus.mem_wr_len);
            if (bus.lsu_err)    observe(EV_ERR, 64'd0, 64'd0, 8'd0);
            if (bus.ifu_rvalid) observe(EV_IRV, 64'd0, bus.ifu_rdata, 8'd0);
            if (bus.lsu_rvalid) observe(EV_LRV, 64'd0, bus.lsu_rdata, 8'd0);
            chk("exclusive_strobes", {62'd0, bus.mem_rd_en && bus.mem_wr_en,
                bus.ifu_gnt && bus.lsu_gnt}, 64'd0);
        end
    end

    always @(negedge clk) begin
        if (bus3.ifu_rvalid || bus3.lsu_rvalid) begin
            rv3_cnt++;
            rv3_cyc = cyc;
            rv3_ifu = bus3.ifu_rvalid;
            rv3_d   = bus3.ifu_rvalid ? bus3.ifu_rdata : bus3.lsu_rdata;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got time limit reached, want bench completion");
        $fatal(1);
    end

    initial begin
        int g, s, d, t, u, base, w;
        wlen = '{8'd1, 8'd2, 8'd8, 8'd0, 8'd3, 8'd16};
        wok  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        rst = 1'b0; rst3 = 1'b0;
        bus.ifu_req = 1'b1; bus.ifu_addr = 64'h8000_0000;
        bus.lsu_req = 1'b1; bus.lsu_we = 1'b1; bus.lsu_addr = 64'h8000_0100;
        bus.lsu_wdata = 64'hDEAD_BEEF; bus.lsu_len = 8'd4;
        bus3.ifu_req = 1'b0; bus3.ifu_addr = '0; bus3.lsu_req = 1'b0; bus3.lsu_we = 1'b0;
        bus3.lsu_addr = '0; bus3.lsu_wdata = '0; bus3.lsu_len = '0;

        // Reset held with both requests pending, then LSU write wins, IFU read follows
        repeat (3) tick();
        rst = 1'b1;
        g = cyc;
        push(EV_LGNT, g, 0, 0, 0);
        push(EV_WR, g + 1, 64'h8000_0100, 64'hDEAD_BEEF, 8'd4);
        push(EV_IGNT, g + 2, 0, 0, 0);
        push(EV_RD, g + 3, 64'h8000_0000, 0, 0);
        push(EV_IRV, g + 5, 0, 64'h1122_3344_5566_7788, 0);
        tick();
        bus.lsu_req = 1'b0;
        chk("busy_in_issue", {63'd0, busy1}, 64'd1);
        tick(); tick();
        bus.ifu_req = 1'b0;
        tick(); tick();

        // Write length table: legal lengths write, illegal ones pulse lsu_err
        for (int i = 0; i < 6; i++) begin
            bus.lsu_req = 1'b1; bus.lsu_we = 1'b1;
            bus.lsu_addr = 64'h8000_0200 + 64'(i * 8);
            bus.lsu_wdata = 64'hA5A5_0000_0000_0000 | 64'(i);
            bus.lsu_len = wlen[i];
            t = cyc;
            push(EV_LGNT, t, 0, 0, 0);
            if (wok[i]) push(EV_WR, t + 1, 64'h8000_0200 + 64'(i * 8),
                             64'hA5A5_0000_0000_0000 | 64'(i), wlen[i]);
            else        push(EV_ERR, t + 1, 0, 0, 0);
            tick();
            bus.lsu_req = 1'b0;
            tick();
        end

        // Both requesters held: LSU x4, IFU, LSU
        bus.lsu_req = 1'b1; bus.lsu_we = 1'b1; bus.lsu_addr = 64'h8000_0500;
        bus.lsu_wdata = 64'h0123_4567_89AB_CDEF; bus.lsu_len = 8'd8;
        bus.ifu_req = 1'b1; bus.ifu_addr = 64'h8000_0008;
        s = cyc;
        for (int k = 0; k < 4; k++) begin
            push(EV_LGNT, s + 2 * k, 0, 0, 0);
            push(EV_WR, s + 2 * k + 1, 64'h8000_0500, 64'h0123_4567_89AB_CDEF, 8'd8);
        end
        push(EV_IGNT, s + 8, 0, 0, 0);
        push(EV_RD, s + 9, 64'h8000_0008, 0, 0);
        push(EV_IRV, s + 11, 0, 64'h7FFF_FFF7_8000_0008, 0);
        push(EV_LGNT, s + 11, 0, 0, 0);
        push(EV_WR, s + 12, 64'h8000_0500, 64'h0123_4567_89AB_CDEF, 8'd8);
        repeat (12) tick();
        bus.lsu_req = 1'b0; bus.ifu_req = 1'b0;
        tick();

        // LSU read, then an IFU grant overlapping the LSU rvalid cycle
        bus.lsu_req = 1'b1; bus.lsu_we = 1'b0; bus.lsu_addr = 64'h8000_0300;
        d = cyc;
        push(EV_LGNT, d, 0, 0, 0);
        push(EV_RD, d + 1, 64'h8000_0300, 0, 0);
        push(EV_LRV, d + 3, 0, 64'h7FFF_FCFF_8000_0300, 0);
        push(EV_IGNT, d + 3, 0, 0, 0);
        push(EV_RD, d + 4, 64'h8000_0010, 0, 0);
        push(EV_IRV, d + 6, 0, 64'h7FFF_FFEF_8000_0010, 0);
        tick();
        bus.lsu_req = 1'b0;
        tick(); tick();
        bus.ifu_req = 1'b1; bus.ifu_addr = 64'h8000_0010;
        tick();
        bus.ifu_req = 1'b0;
        tick(); tick();
        chk("lsu_rdata_held", bus.lsu_rdata, 64'h7FFF_FCFF_8000_0300);
        repeat (3) tick();
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        // RD_LAT=3 instance: reset lands during WAIT, then a fresh IFU read
        bus3.lsu_req = 1'b1; bus3.lsu_we = 1'b0; bus3.lsu_addr = 64'h8000_0040;
        tick();
        rst3 = 1'b1;
        #1;
        t = cyc;
        chk("r3_lsu_gnt", {63'd0, bus3.lsu_gnt}, 64'd1);
        tick();
        bus3.lsu_req = 1'b0;
        tick();
        chk("r3_rd_en_in_wait", {63'd0, bus3.mem_rd_en}, 64'd1);
        chk("r3_busy_in_wait", {63'd0, busy3}, 64'd1);
        base = rv3_cnt;
        rst3 = 1'b0;
        tick();
        chk("r3_rd_en_after_reset", {63'd0, bus3.mem_rd_en}, 64'd0);
        chk("r3_busy_after_reset", {63'd0, busy3}, 64'd0);
        rst3 = 1'b1;
        repeat (5) tick();
        chk("r3_no_rvalid_after_reset", 64'(rv3_cnt - base), 64'd0);
        bus3.ifu_req = 1'b1; bus3.ifu_addr = 64'h8000_0020;
        #1;
        u = cyc;
        chk("r3_ifu_gnt", {63'd0, bus3.ifu_gnt}, 64'd1);
        tick();
        bus3.ifu_req = 1'b0;
        base = rv3_cnt;
        w = 0;
        while (rv3_cnt == base && w < 12) begin
            tick();
            w++;
        end
        chk("r3_rvalid_seen", 64'(rv3_cnt - base), 64'd1);
        chk("r3_rvalid_cycle", 64'(rv3_cyc - u), 64'd5);
        chk("r3_rvalid_is_ifu", {63'd0, rv3_ifu}, 64'd1);
        chk("r3_rdata", rv3_d, 64'h7FFF_FFDF_8000_0020);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single data-memory port (rd_en/rd_addr/rd_data, wr_en/wr_addr/wr_data/wr_len) between the instruction-fetch unit (IFU, read-only) and the load/store unit (LSU, read/write).
- Sits between the core front-end/LSU and the DPI-backed data memory.
- Fixed-priority arbitration (LSU first), with an anti-starvation counter for the IFU.
- Sequences each access through a small FSM with registered memory-side outputs.

Parameters:
- RD_LAT, 1: cycles from mem_rd_en asserted to mem_rd_data valid (legal 1..7).
- STARVE_MAX, 4: consecutive LSU wins while IFU is requesting before IFU is forced to win (legal 1..15).

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous, active-low reset.
- ifu_req  in  1  IFU read request; held until ifu_gnt.
- ifu_addr  in  64  IFU read address.
- ifu_gnt  out  1  IFU request accepted this cycle.
- ifu_rvalid  out  1  one-cycle pulse; ifu_rdata valid.
- ifu_rdata  out  64  IFU read data.
- lsu_req  in  1  LSU request; held with all fields until lsu_gnt.
- lsu_we  in  1  1 = write, 0 = read.
- lsu_addr  in  64  LSU address.
- lsu_wdata  in  64  LSU write data.
- lsu_len  in  8  write length in bytes (1/2/4/8).
- lsu_gnt  out  1  LSU request accepted this cycle.
- lsu_rvalid  out  1  one-cycle pulse; lsu_rdata valid.
- lsu_rdata  out  64  LSU read data.
- lsu_err  out  1  one-cycle pulse; illegal write length dropped.
- mem_rd_en  out  1  memory read enable.
- mem_rd_addr  out  64  memory read address.
- mem_rd_data  in  64  memory read data.
- mem_wr_en  out  1  memory write enable.
- mem_wr_addr  out  64  memory write address.
- mem_wr_data  out  64  memory write data.
- mem_wr_len  out  8  memory write length.
- busy  out  1  FSM not in IDLE.

Behaviour:
- Reset (rst == 0 at posedge):
  - state = IDLE; starve_cnt = 0; wait counter = 0.
  - All outputs 0, including data and address outputs.
  - Any in-flight access is abandoned: no rvalid is issued and no write is performed after reset.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Grants are combinational and issued only in IDLE.
  - Winner selection:
    - lsu_req && !(ifu_req && starve_cnt == STARVE_MAX) → LSU wins.
    - else ifu_req → IFU wins.
  - The winner's gnt is high for exactly this cycle.
  - On grant, the owner, we, addr, wdata and len are registered; next state = ISSUE.
  - With no request: stay in IDLE, gnt = 0.
- starve_cnt:
  - Increments (saturating at STARVE_MAX) when LSU wins while ifu_req is high.
  - Clears to 0 when IFU wins, or when ifu_req is low in IDLE.
- ISSUE (1 cycle):
  - Read: mem_rd_en = 1, mem_rd_addr = latched address; load wait counter = RD_LAT − 1; next state = WAIT if RD_LAT > 1, else RESP.
  - Write with len ∈ {1,2,4,8}: mem_wr_en = 1 with latched addr/data/len; next state = IDLE.
  - Write with any other len: mem_wr_en stays 0; lsu_err = 1; next state = IDLE.
- WAIT:
  - mem_rd_en stays high and mem_rd_addr is held.
  - Counter decrements; go to RESP when it reaches 0.
- RESP (1 cycle):
  - mem_rd_data is copied to the owner's rdata register.
  - Owner's rvalid = 1 in the following cycle (registered), i.e. IDLE + 1 cycle.
  - mem_rd_en drops; next state = IDLE.
  - rdata holds its value until the next response to that requester.
- Latency from grant cycle G:
  - Write: mem_wr_en at G+1; next grant possible at G+2.
  - Read: mem_rd_en over G+1 .. G+RD_LAT; rvalid at G+RD_LAT+2; next grant possible at G+RD_LAT+2 (this grant overlaps the rvalid cycle).
- Exclusivity: mem_rd_en and mem_wr_en are never high together; ifu_gnt and lsu_gnt are never high together.
- Simultaneous requests: the IFU is never granted twice in a row while lsu_req is held, unless the LSU is idle.
- Requester deasserting req before gnt: legal; the request is simply not taken.
- Addresses are passed through unmodified; no alignment checking is performed.

Test Plan:
- Reset: hold rst = 0 for 3 cycles with both req high → all outputs 0, no gnt; release → lsu_gnt in the first cycle after release.
- IFU read, RD_LAT = 1: ifu_addr = 0x8000_0000, memory returns 0x1122_3344_5566_7788 → ifu_gnt at G, mem_rd_en at G+1 with that address, ifu_rvalid at G+3 with that data.
- LSU write: addr = 0x8000_0100, wdata = 0xDEAD_BEEF, len = 4 → mem_wr_en for exactly one cycle at G+1 with those values; lsu_rvalid never asserted.
- Illegal len = 3 write → no mem_wr_en; lsu_err pulses at G+1; FSM returns to IDLE.
- Starvation, STARVE_MAX = 4: both req held continuously → grant sequence LSU, LSU, LSU, LSU, IFU, LSU...
- Reset mid-read, RD_LAT = 3: drive rst = 0 during WAIT → no rvalid; mem_rd_en = 0 after the reset edge; a subsequent read completes normally.
